// File: rtl/picomips_pkg.sv
// Shared types and encodings for the picoMIPS control path.
// Opcode layout: [5:4] class, [3] immediate select, [2:0] function/condition.
package picomips_pkg;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_MUL    = 2'b10,
    CLS_SYS    = 2'b11
  } opclass_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    HALT     = 2'd2
  } fsm_state_t;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_BNE  = 6'b010001;
  localparam logic [5:0] OP_BLT  = 6'b010010;
  localparam logic [5:0] OP_BRA  = 6'b010011;
  localparam logic [5:0] OP_MUL  = 6'b100000;
  localparam logic [5:0] OP_MULI = 6'b101000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/mul_sequencer.sv
// Loadable down-counter timing a multi-cycle multiply; done marks the final cycle.
module mul_sequencer #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(MUL_CYCLES - 1);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/control_fsm.sv
// Stateful picoMIPS decoder: combinational controls from opcode, FSM state and the
// registered flags; adds multiply stall sequencing, HALT and a sticky illegal flag.
module control_fsm
  import picomips_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 6,
  parameter int unsigned ALU_FUNC_W = 3,
  parameter int unsigned FLAG_W     = 4,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FLAG_W-1:0]     alu_flags,
  output logic                  imm,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  w,
  output logic                  pc_incr,
  output logic                  pc_relbranch,
  output logic                  mul_start,
  output logic                  halted,
  output logic                  illegal
);

  fsm_state_t        state_q, state_d;
  logic [FLAG_W-1:0] flag_q;
  logic              illegal_q;
  logic              flag_load;
  logic              illegal_set;
  logic              mul_load;
  logic              mul_done;
  logic              unused_flags;
  opclass_t          op_class;

  logic                  imm_d, w_d, pc_incr_d, relbranch_d, mul_start_d;
  logic [ALU_FUNC_W-1:0] alu_func_d;

  assign op_class     = opclass_t'(opcode[5:4]);
  assign unused_flags = flag_q[FLAG_C];

  mul_sequencer #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_sequencer (
    .clk   (clk),
    .reset (reset),
    .load  (mul_load),
    .en    (state_q == MUL_WAIT),
    .done  (mul_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      flag_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flag_load) flag_q <= alu_flags;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    imm_d       = 1'b0;
    alu_func_d  = '0;
    w_d         = 1'b0;
    pc_incr_d   = 1'b0;
    relbranch_d = 1'b0;
    mul_start_d = 1'b0;
    flag_load   = 1'b0;
    illegal_set = 1'b0;
    mul_load    = 1'b0;

    case (state_q)
      RUN: begin
        pc_incr_d = 1'b1;
        case (op_class)
          CLS_ALU: begin
            if (opcode[5:0] != OP_NOP) begin
              w_d        = 1'b1;
              imm_d      = opcode[3];
              alu_func_d = opcode[ALU_FUNC_W-1:0];
              flag_load  = 1'b1;
            end
          end
          CLS_BRANCH: begin
            // Condition reads the flag register, so a branch sees the previous ALU op.
            case (opcode[5:0])
              OP_BEQ:  relbranch_d = flag_q[FLAG_Z];
              OP_BNE:  relbranch_d = !flag_q[FLAG_Z];
              OP_BLT:  relbranch_d = flag_q[FLAG_N] ^ flag_q[FLAG_V];
              OP_BRA:  relbranch_d = 1'b1;
              default: illegal_set = 1'b1;
            endcase
          end
          CLS_MUL: begin
            if ((opcode[5:0] == OP_MUL) || (opcode[5:0] == OP_MULI)) begin
              imm_d       = opcode[3];
              alu_func_d  = opcode[ALU_FUNC_W-1:0];
              mul_start_d = 1'b1;
              pc_incr_d   = 1'b0;
              mul_load    = 1'b1;
              state_d     = MUL_WAIT;
            end else begin
              illegal_set = 1'b1;
            end
          end
          CLS_SYS: begin
            if (opcode[5:0] == OP_HALT) begin
              pc_incr_d = 1'b0;
              state_d   = HALT;
            end else begin
              illegal_set = 1'b1;
            end
          end
          default: illegal_set = 1'b1;
        endcase
      end
      MUL_WAIT: begin
        imm_d      = opcode[3];
        alu_func_d = opcode[ALU_FUNC_W-1:0];
        if (mul_done) begin
          w_d       = 1'b1;
          pc_incr_d = 1'b1;
          flag_load = 1'b1;
          state_d   = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = RUN;
    endcase
  end

  // Datapath strobes are forced low while reset is held so a multiply in flight never writes.
  always_comb begin
    imm          = imm_d;
    alu_func     = alu_func_d;
    w            = w_d;
    pc_incr      = pc_incr_d;
    pc_relbranch = relbranch_d;
    mul_start    = mul_start_d;
    if (reset) begin
      imm          = 1'b0;
      alu_func     = '0;
      w            = 1'b0;
      pc_incr      = 1'b0;
      pc_relbranch = 1'b0;
      mul_start    = 1'b0;
    end
  end

  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: each applied vector queues its expected controls,
// which are popped and compared against the DUT mid-cycle.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [3:0] alu_flags;
  logic       imm;
  logic [2:0] alu_func;
  logic       w;
  logic       pc_incr;
  logic       pc_relbranch;
  logic       mul_start;
  logic       halted;
  logic       illegal;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  control_fsm #(
    .OPCODE_W   (6),
    .ALU_FUNC_W (3),
    .FLAG_W     (4),
    .MUL_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .alu_flags    (alu_flags),
    .imm          (imm),
    .alu_func     (alu_func),
    .w            (w),
    .pc_incr      (pc_incr),
    .pc_relbranch (pc_relbranch),
    .mul_start    (mul_start),
    .halted       (halted),
    .illegal      (illegal)
  );

  // Packed as {imm, alu_func, w, pc_incr, pc_relbranch, mul_start, halted, illegal}.
  function automatic logic [9:0] ov(input logic i, input logic [2:0] f, input logic wr,
                                    input logic pc, input logic rb, input logic ms,
                                    input logic h, input logic il);
    return {i, f, wr, pc, rb, ms, h, il};
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (imm,func,w,pc,rb,ms,halt,ill)", tag, got, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [5:0] op, input logic [3:0] fl,
                     input logic rst, input logic [9:0] exp);
    logic [9:0] e;
    string      t;
    @(negedge clk);
    reset     = rst;
    opcode    = op;
    alu_flags = fl;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {imm, alu_func, w, pc_incr, pc_relbranch, mul_start, halted, illegal}, e);
  endtask

  localparam logic [5:0] ADD   = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUB   = 6'b000011;
  localparam logic [5:0] NOP   = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b010000;
  localparam logic [5:0] BNE   = 6'b010001;
  localparam logic [5:0] BLT   = 6'b010010;
  localparam logic [5:0] BRA   = 6'b010011;
  localparam logic [5:0] MUL   = 6'b100000;
  localparam logic [5:0] MULI  = 6'b101000;
  localparam logic [5:0] HLT   = 6'b111111;
  localparam logic [5:0] ILL0  = 6'b110000;
  localparam logic [5:0] ILLB  = 6'b010100;

  initial begin
    reset     = 1'b1;
    opcode    = NOP;
    alu_flags = 4'b0000;
    @(posedge clk);

    vec("reset_hold", ADD, 4'b0000, 1'b1, ov(0, 3'b000, 0, 0, 0, 0, 0, 0));
    vec("add",        ADD, 4'b0000, 1'b0, ov(0, 3'b010, 1, 1, 0, 0, 0, 0));
    vec("addi",      ADDI, 4'b0000, 1'b0, ov(1, 3'b010, 1, 1, 0, 0, 0, 0));

    vec("sub_z",      SUB, 4'b0001, 1'b0, ov(0, 3'b011, 1, 1, 0, 0, 0, 0));
    vec("beq_taken",  BEQ, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vec("sub_nz",     SUB, 4'b0000, 1'b0, ov(0, 3'b011, 1, 1, 0, 0, 0, 0));
    vec("beq_not",    BEQ, 4'b0001, 1'b0, ov(0, 3'b000, 0, 1, 0, 0, 0, 0));
    vec("sub_v",      SUB, 4'b1000, 1'b0, ov(0, 3'b011, 1, 1, 0, 0, 0, 0));
    vec("blt_taken",  BLT, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vec("bne_taken",  BNE, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vec("bra",        BRA, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vec("nop",        NOP, 4'b1111, 1'b0, ov(0, 3'b000, 0, 1, 0, 0, 0, 0));
    vec("blt_kept",   BLT, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));

    vec("mul_c1",     MUL, 4'b0000, 1'b0, ov(0, 3'b000, 0, 0, 0, 1, 0, 0));
    vec("mul_c2",     MUL, 4'b0000, 1'b0, ov(0, 3'b000, 0, 0, 0, 0, 0, 0));
    vec("mul_c3",     MUL, 4'b0000, 1'b0, ov(0, 3'b000, 0, 0, 0, 0, 0, 0));
    vec("mul_c4",     MUL, 4'b0001, 1'b0, ov(0, 3'b000, 1, 1, 0, 0, 0, 0));
    vec("mul_flags",  BEQ, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));

    vec("muli_c1",   MULI, 4'b0000, 1'b0, ov(1, 3'b000, 0, 0, 0, 1, 0, 0));
    vec("muli_c2",   MULI, 4'b0001, 1'b0, ov(1, 3'b000, 0, 0, 0, 0, 0, 0));
    vec("muli_c3",   MULI, 4'b0001, 1'b0, ov(1, 3'b000, 0, 0, 0, 0, 0, 0));
    vec("muli_c4",   MULI, 4'b0000, 1'b0, ov(1, 3'b000, 1, 1, 0, 0, 0, 0));
    vec("muli_flags", BNE, 4'b0001, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));

    vec("ill_sys",   ILL0, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 0, 0, 0, 0));
    vec("ill_sticky", ADD, 4'b0000, 1'b0, ov(0, 3'b010, 1, 1, 0, 0, 0, 1));
    vec("ill_branch",ILLB, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 0, 0, 0, 1));
    vec("ill_hold",   BRA, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 1));

    vec("halt_dec",   HLT, 4'b0000, 1'b0, ov(0, 3'b000, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      vec("halt_stay", ADD, 4'b0000, 1'b0, ov(0, 3'b000, 0, 0, 0, 0, 1, 1));
    vec("halt_reset", ADD, 4'b0000, 1'b1, ov(0, 3'b000, 0, 0, 0, 0, 1, 1));
    vec("after_rst",  ADD, 4'b0001, 1'b0, ov(0, 3'b010, 1, 1, 0, 0, 0, 0));

    vec("pre_mul_z",  SUB, 4'b0001, 1'b0, ov(0, 3'b011, 1, 1, 0, 0, 0, 0));
    vec("abort_c1",   MUL, 4'b0001, 1'b0, ov(0, 3'b000, 0, 0, 0, 1, 0, 0));
    vec("abort_rst",  MUL, 4'b0001, 1'b1, ov(0, 3'b000, 0, 0, 0, 0, 0, 0));
    vec("abort_bne",  BNE, 4'b0001, 1'b0, ov(0, 3'b000, 0, 1, 1, 0, 0, 0));
    vec("abort_idle", NOP, 4'b0000, 1'b0, ov(0, 3'b000, 0, 1, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
